// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data wins contention until fetch has lost STARVE_LIMIT times in a row.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              busy
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_D} grant_t;

    state_t          state;
    grant_t          grant;
    logic [CW-1:0]   wait_cnt;
    logic [SW-1:0]   starve_cnt;
    logic            lat_we;
    logic            starved;
    logic            if_wins;
    logic            d_wins;

    always_comb begin
        starved = (starve_cnt == SW'(STARVE_LIMIT));
        if_wins = if_req & (~d_req | starved);
        d_wins  = d_req & ~(if_req & starved);
    end

    // mem_* registers double as the latched request: loaded at accept,
    // driven for the single ISSUE cycle, then cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GNT_NONE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            lat_we     <= 1'b0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        grant     <= GNT_D;
                        lat_we    <= d_we;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (if_req && !starved)
                            starve_cnt <= starve_cnt + 1'b1;
                        state <= ISSUE;
                    end else if (if_wins) begin
                        grant      <= GNT_IF;
                        lat_we     <= 1'b0;
                        mem_en     <= 1'b1;
                        mem_addr   <= if_addr;
                        starve_cnt <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= CW'(LATENCY - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        if (!lat_we) begin
                            if (grant == GNT_D)
                                d_rdata <= mem_rdata;
                            else
                                if_rdata <= mem_rdata;
                        end
                        if_ack <= (grant == GNT_IF);
                        d_ack  <= (grant == GNT_D);
                        state  <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    grant <= GNT_NONE;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected acks are queued at request
// time and matched when the DUT acks; LATENCY=1/5 builds run alongside.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic        if_req = 0, d_req = 0, d_we = 0, zero = 0;
    logic [15:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata, lat_rdata = 0;
    logic        if_ack, d_ack, mem_en, mem_we, stall, busy;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    logic        l1_req = 0, l1_if_ack, l1_d_ack, l1_mem_en, l1_mem_we, l1_stall, l1_busy;
    logic [15:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
    logic        l5_req = 0, l5_if_ack, l5_d_ack, l5_mem_en, l5_mem_we, l5_stall, l5_busy;
    logic [15:0] l5_if_rdata, l5_d_rdata, l5_mem_addr, l5_mem_wdata;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall(stall), .busy(busy));

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1), .STARVE_LIMIT(4)) u_l1 (
        .clk(clk), .rst(rst), .if_req(l1_req), .if_addr(if_addr), .if_ack(l1_if_ack),
        .if_rdata(l1_if_rdata), .d_req(zero), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(l1_d_ack), .d_rdata(l1_d_rdata), .mem_en(l1_mem_en), .mem_we(l1_mem_we),
        .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_rdata(lat_rdata),
        .stall(l1_stall), .busy(l1_busy));

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(5), .STARVE_LIMIT(4)) u_l5 (
        .clk(clk), .rst(rst), .if_req(l5_req), .if_addr(if_addr), .if_ack(l5_if_ack),
        .if_rdata(l5_if_rdata), .d_req(zero), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(l5_d_ack), .d_rdata(l5_d_rdata), .mem_en(l5_mem_en), .mem_we(l5_mem_we),
        .mem_addr(l5_mem_addr), .mem_wdata(l5_mem_wdata), .mem_rdata(lat_rdata),
        .stall(l5_stall), .busy(l5_busy));

    function automatic logic [15:0] memval(input logic [15:0] a);
        return a ^ 16'hA5D3;
    endfunction

    // Memory model for the LATENCY=2 build: read data valid only 2 cycles after mem_en.
    logic        p1_v = 0, p2_v = 0;
    logic [15:0] p1_a = 0, p2_a = 0;
    always @(posedge clk) begin
        p1_v <= (mem_en === 1'b1) && (mem_we === 1'b0);
        p1_a <= mem_addr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign mem_rdata = p2_v ? memval(p2_a) : 16'hEEEE;

    typedef struct {
        bit          is_data;
        int          ack_cyc;
        logic [15:0] exp_if;
        logic [15:0] exp_d;
    } ack_t;
    ack_t        sb[$];
    logic [15:0] m_if = 0, m_d = 0;

    task automatic push_fetch(input logic [15:0] a, input int ack_cyc);
        m_if = memval(a);
        sb.push_back('{1'b0, ack_cyc, m_if, m_d});
    endtask

    task automatic push_data(input logic we, input logic [15:0] a, input int ack_cyc);
        if (!we) m_d = memval(a);
        sb.push_back('{1'b1, ack_cyc, m_if, m_d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) tick();
        #4;
        checks++;
        if ({if_ack, d_ack, mem_en, mem_we, stall, busy, if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs ack=%b/%b en=%b we=%b stall=%b busy=%b ird=%h drd=%h ma=%h mw=%h required all 0",
                     if_ack, d_ack, mem_en, mem_we, stall, busy, if_rdata, d_rdata, mem_addr, mem_wdata);
        end
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_single_fetch();
        int   t0 = cyc;
        ack_t e;
        if_req = 1; if_addr = 16'h0010;
        push_fetch(16'h0010, t0 + 4);
        for (int k = 0; k <= 5; k++) begin
            if (k == 5) if_req = 0;
            #4;
            checks++;
            if (stall !== (k <= 3) || busy !== (k >= 1 && k <= 4) || mem_en !== (k == 1)) begin
                failures++;
                $display("FAIL fetch_ctrl k=%0d stall=%b busy=%b mem_en=%b required %b %b %b",
                         k, stall, busy, mem_en, k <= 3, k >= 1 && k <= 4, k == 1);
            end
            if (k == 1) begin
                checks++;
                if (mem_we !== 1'b0 || mem_addr !== 16'h0010) begin
                    failures++;
                    $display("FAIL fetch_issue mem_we=%b mem_addr=%h required 0 0010", mem_we, mem_addr);
                end
            end
            if (if_ack || d_ack) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL fetch_ack unexpected if_ack=%b d_ack=%b cyc=%0d", if_ack, d_ack, cyc);
                end else begin
                    e = sb.pop_front();
                    if ({d_ack, if_ack} !== {e.is_data, ~e.is_data} || cyc != e.ack_cyc ||
                        if_rdata !== e.exp_if || d_rdata !== e.exp_d) begin
                        failures++;
                        $display("FAIL fetch_ack got d/if=%b%b cyc=%0d ird=%h drd=%h required d=%b cyc=%0d ird=%h drd=%h",
                                 d_ack, if_ack, cyc, if_rdata, d_rdata, e.is_data, e.ack_cyc, e.exp_if, e.exp_d);
                    end
                end
            end
            tick();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL fetch_missing_ack pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_simultaneous();
        int   t0 = cyc;
        ack_t e;
        if_req = 1; if_addr = 16'h0040;
        d_req = 1; d_we = 0; d_addr = 16'h0300;
        push_data(1'b0, 16'h0300, t0 + 4);
        push_fetch(16'h0040, t0 + 9);
        for (int k = 0; k <= 10; k++) begin
            if (k == 5) d_req = 0;
            if (k == 10) if_req = 0;
            #4;
            checks++;
            if (mem_en !== (k == 1 || k == 6) ||
                (k == 1 && mem_addr !== 16'h0300) || (k == 6 && mem_addr !== 16'h0040)) begin
                failures++;
                $display("FAIL simul_issue k=%0d mem_en=%b mem_addr=%h required en=%b addr=%h",
                         k, mem_en, mem_addr, k == 1 || k == 6, (k == 6) ? 16'h0040 : 16'h0300);
            end
            if (if_ack || d_ack) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL simul_ack unexpected if_ack=%b d_ack=%b cyc=%0d", if_ack, d_ack, cyc);
                end else begin
                    e = sb.pop_front();
                    if ({d_ack, if_ack} !== {e.is_data, ~e.is_data} || cyc != e.ack_cyc ||
                        if_rdata !== e.exp_if || d_rdata !== e.exp_d) begin
                        failures++;
                        $display("FAIL simul_ack got d/if=%b%b cyc=%0d ird=%h drd=%h required d=%b cyc=%0d ird=%h drd=%h",
                                 d_ack, if_ack, cyc, if_rdata, d_rdata, e.is_data, e.ack_cyc, e.exp_if, e.exp_d);
                    end
                end
            end
            tick();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL simul_missing_ack pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_store();
        int   t0 = cyc;
        ack_t e;
        d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
        push_data(1'b1, 16'h0200, t0 + 4);
        for (int k = 0; k <= 5; k++) begin
            if (k == 5) begin d_req = 0; d_we = 0; end
            #4;
            checks++;
            if (k == 1) begin
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0200 || mem_wdata !== 16'h1234) begin
                    failures++;
                    $display("FAIL store_issue en=%b we=%b addr=%h wdata=%h required 1 1 0200 1234",
                             mem_en, mem_we, mem_addr, mem_wdata);
                end
            end else if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
                failures++;
                $display("FAIL store_idle k=%0d en=%b we=%b required 0 0", k, mem_en, mem_we);
            end
            if (if_ack || d_ack) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL store_ack unexpected if_ack=%b d_ack=%b cyc=%0d", if_ack, d_ack, cyc);
                end else begin
                    e = sb.pop_front();
                    if ({d_ack, if_ack} !== {e.is_data, ~e.is_data} || cyc != e.ack_cyc ||
                        if_rdata !== e.exp_if || d_rdata !== e.exp_d) begin
                        failures++;
                        $display("FAIL store_ack got d/if=%b%b cyc=%0d ird=%h drd=%h required d=%b cyc=%0d ird=%h drd=%h",
                                 d_ack, if_ack, cyc, if_rdata, d_rdata, e.is_data, e.ack_cyc, e.exp_if, e.exp_d);
                    end
                end
            end
            tick();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL store_missing_ack pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_starvation();
        int          t0 = cyc;
        ack_t        e;
        logic [15:0] exp_addr;
        if_req = 1; if_addr = 16'h0050;
        d_req = 1; d_we = 0; d_addr = 16'h0310;
        for (int n = 0; n < 4; n++) push_data(1'b0, 16'h0310, t0 + 4 + 5 * n);
        push_fetch(16'h0050, t0 + 24);
        push_data(1'b0, 16'h0310, t0 + 29);
        for (int k = 0; k <= 30; k++) begin
            if (k == 30) begin if_req = 0; d_req = 0; end
            #4;
            if (k % 5 == 1 && k < 30) begin
                exp_addr = (k == 21) ? 16'h0050 : 16'h0310;
                checks++;
                if (mem_en !== 1'b1 || mem_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL starve_grant k=%0d mem_en=%b mem_addr=%h required 1 %h", k, mem_en, mem_addr, exp_addr);
                end
            end
            if (if_ack || d_ack) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL starve_ack unexpected if_ack=%b d_ack=%b cyc=%0d", if_ack, d_ack, cyc);
                end else begin
                    e = sb.pop_front();
                    if ({d_ack, if_ack} !== {e.is_data, ~e.is_data} || cyc != e.ack_cyc ||
                        if_rdata !== e.exp_if || d_rdata !== e.exp_d) begin
                        failures++;
                        $display("FAIL starve_ack got d/if=%b%b cyc=%0d ird=%h drd=%h required d=%b cyc=%0d ird=%h drd=%h",
                                 d_ack, if_ack, cyc, if_rdata, d_rdata, e.is_data, e.ack_cyc, e.exp_if, e.exp_d);
                    end
                end
            end
            tick();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL starve_missing_ack pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_latency_builds();
        l1_req = 1; l5_req = 1; if_addr = 16'h0060;
        for (int k = 0; k <= 9; k++) begin
            lat_rdata = 16'h1000 + 16'(k);
            if (k == 4) l1_req = 0;
            if (k == 8) l5_req = 0;
            #4;
            checks++;
            if (l1_if_ack !== (k == 3) || l5_if_ack !== (k == 7) || l1_mem_en !== (k == 1) || l5_mem_en !== (k == 1)) begin
                failures++;
                $display("FAIL latency_timing k=%0d l1_ack=%b l5_ack=%b l1_en=%b l5_en=%b required %b %b %b %b",
                         k, l1_if_ack, l5_if_ack, l1_mem_en, l5_mem_en, k == 3, k == 7, k == 1, k == 1);
            end
            if (k == 3) begin
                checks++;
                if (l1_if_rdata !== 16'h1002) begin
                    failures++;
                    $display("FAIL latency1_rdata got %h required 1002", l1_if_rdata);
                end
            end
            if (k == 7) begin
                checks++;
                if (l5_if_rdata !== 16'h1006) begin
                    failures++;
                    $display("FAIL latency5_rdata got %h required 1006", l5_if_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int   t0 = cyc;
        ack_t e;
        d_req = 1; d_we = 0; d_addr = 16'h0320;
        for (int k = 0; k <= 9; k++) begin
            if (k == 2) begin rst = 1; d_req = 0; m_if = 0; m_d = 0; end
            if (k == 3) rst = 0;
            if (k == 4) begin
                if_req = 1; if_addr = 16'h0070;
                push_fetch(16'h0070, t0 + 8);
            end
            if (k == 9) if_req = 0;
            #4;
            if (k == 2) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL midrst_pre busy=%b required 1", busy);
                end
            end
            if (k == 3) begin
                checks++;
                if ({if_ack, d_ack, mem_en, mem_we, stall, busy, if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
                    failures++;
                    $display("FAIL midrst_outputs ack=%b/%b en=%b busy=%b ird=%h drd=%h required all 0",
                             if_ack, d_ack, mem_en, busy, if_rdata, d_rdata);
                end
            end
            if (if_ack || d_ack) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL midrst_ack unexpected if_ack=%b d_ack=%b cyc=%0d", if_ack, d_ack, cyc);
                end else begin
                    e = sb.pop_front();
                    if ({d_ack, if_ack} !== {e.is_data, ~e.is_data} || cyc != e.ack_cyc ||
                        if_rdata !== e.exp_if || d_rdata !== e.exp_d) begin
                        failures++;
                        $display("FAIL midrst_ack got d/if=%b%b cyc=%0d ird=%h drd=%h required d=%b cyc=%0d ird=%h drd=%h",
                                 d_ack, if_ack, cyc, if_rdata, d_rdata, e.is_data, e.ack_cyc, e.exp_if, e.exp_d);
                    end
                end
            end
            tick();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL midrst_missing_ack pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_store();
        test_starvation();
        test_latency_builds();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
